// File: rtl/matrix_operand_loader_if.sv
// Stream and bank-write signal bundle for matrix_operand_loader.
// The slave modport is the loader; the master modport is the source/datapath side.
interface matrix_operand_loader_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              register_ready;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic [CW-1:0]     count;
    logic              bank_release;
    logic              ovf_err;

    modport master (
        output start, in_valid, in_data, bank_release,
        input  in_ready, register_ready, wr_addr, wr_data, full, count, ovf_err
    );

    modport slave (
        input  start, in_valid, in_data, bank_release,
        output in_ready, register_ready, wr_addr, wr_data, full, count, ovf_err
    );
endinterface

// File: rtl/matrix_operand_loader.sv
// Loads DEPTH stream elements into the operand bank, one register_ready strobe per element,
// then holds the bank until released. Define LOADER_OVF_EN to build the sticky overflow detector.
module matrix_operand_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    matrix_operand_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q;
    logic          accept;
    logic          last;

    // in_ready is decoded from the state register only, so accept has no path from in_valid to in_ready.
    assign accept = bus.in_valid && (state_q == LOAD);
    assign last   = (count_q == CW'(DEPTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        bus.full     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                if (accept && last) state_d = FULL;
            end
            FULL: begin
                bus.full = 1'b1;
                if (bus.bank_release) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q            <= '0;
            bus.wr_addr        <= '0;
            bus.wr_data        <= '0;
            bus.register_ready <= 1'b0;
        end else begin
            bus.register_ready <= accept;
            if (accept) begin
                bus.wr_addr <= count_q[AW-1:0];
                bus.wr_data <= bus.in_data;
                count_q     <= count_q + CW'(1);
            end else if (state_q == FULL && bus.bank_release) begin
                count_q <= '0;
            end
        end
    end

    assign bus.count = count_q;

`ifdef LOADER_OVF_EN
    logic ovf_q;

    // Sticky until reset: a source pushing into a held bank is a protocol error worth keeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               ovf_q <= 1'b0;
        else if (state_q == FULL && bus.in_valid) ovf_q <= 1'b1;
    end

    assign bus.ovf_err = ovf_q;
`else
    assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed self-checking bench for matrix_operand_loader (DEPTH=16, DATA_W=8).
module tb_matrix_operand_loader;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

`ifdef LOADER_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    matrix_operand_loader_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    matrix_operand_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle just past the edge; inputs changed here apply at the next edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.bank_release = 1'b0;
        cycle();
        cycle();
        total++;
        if ({bus.in_ready, bus.register_ready, bus.full, bus.count, bus.wr_addr, bus.wr_data, bus.ovf_err} !== '0)
            $display("FAIL reset_state: rdy=%b strb=%b full=%b cnt=%0d addr=%0d data=%h ovf=%b, required all 0",
                     bus.in_ready, bus.register_ready, bus.full, bus.count, bus.wr_addr, bus.wr_data, bus.ovf_err);
        else passed++;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_burst();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1) $display("FAIL burst_ready_after_start: in_ready=%b required 1", bus.in_ready);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i + 1);
            cycle();
            total++;
            if ({bus.register_ready, bus.wr_addr, bus.wr_data, bus.count, bus.full} !==
                {1'b1, 4'(i), 8'(i + 1), 5'(i + 1), (i == DEPTH - 1)})
                $display("FAIL burst_elem%0d: strb=%b addr=%0d data=%h cnt=%0d full=%b, required 1/%0d/%h/%0d/%b",
                         i, bus.register_ready, bus.wr_addr, bus.wr_data, bus.count, bus.full,
                         i, 8'(i + 1), i + 1, (i == DEPTH - 1));
            else passed++;
        end
        bus.in_valid = 1'b0;
        cycle();
        total++;
        if ({bus.register_ready, bus.full, bus.in_ready, bus.count} !== {1'b0, 1'b1, 1'b0, 5'd16})
            $display("FAIL burst_hold: strb=%b full=%b rdy=%b cnt=%0d, required 0/1/0/16",
                     bus.register_ready, bus.full, bus.in_ready, bus.count);
        else passed++;
    endtask

    // Entered with the bank FULL.
    task automatic test_overflow();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        cycle();
        total++;
        if ({bus.register_ready, bus.in_ready, bus.full, bus.ovf_err, bus.count} !== {1'b0, 1'b0, 1'b1, OVF_EXP, 5'd16})
            $display("FAIL ovf_push: strb=%b rdy=%b full=%b ovf=%b cnt=%0d, required 0/0/1/%b/16",
                     bus.register_ready, bus.in_ready, bus.full, bus.ovf_err, bus.count, OVF_EXP);
        else passed++;
        bus.in_valid     = 1'b0;
        bus.bank_release = 1'b1;
        cycle();
        bus.bank_release = 1'b0;
        total++;
        if ({bus.full, bus.count, bus.in_ready, bus.register_ready, bus.ovf_err} !== {1'b0, 5'd0, 1'b0, 1'b0, OVF_EXP})
            $display("FAIL ovf_release: full=%b cnt=%0d rdy=%b strb=%b ovf=%b, required 0/0/0/0/%b",
                     bus.full, bus.count, bus.in_ready, bus.register_ready, bus.ovf_err, OVF_EXP);
        else passed++;
        cycle();
        total++;
        if ({bus.ovf_err, bus.in_ready} !== {OVF_EXP, 1'b0})
            $display("FAIL ovf_sticky_idle: ovf=%b rdy=%b, required %b/0", bus.ovf_err, bus.in_ready, OVF_EXP);
        else passed++;
    endtask

    task automatic test_gaps();
        int k;
        k = 0;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int c = 0; c < 2 * DEPTH; c++) begin
            bus.in_valid = (c % 2 == 0);
            bus.in_data  = 8'(8'h20 + k);
            cycle();
            total++;
            if (c % 2 == 0) begin
                if ({bus.register_ready, bus.wr_addr, bus.wr_data, bus.full} !==
                    {1'b1, 4'(k), 8'(8'h20 + k), (k == DEPTH - 1)})
                    $display("FAIL gap_elem%0d: strb=%b addr=%0d data=%h full=%b, required 1/%0d/%h/%b",
                             k, bus.register_ready, bus.wr_addr, bus.wr_data, bus.full, k, 8'(8'h20 + k), (k == DEPTH - 1));
                else passed++;
                k++;
            end else begin
                if ({bus.register_ready, bus.count, bus.full} !== {1'b0, 5'(k), (k == DEPTH)})
                    $display("FAIL gap_idle_cycle%0d: strb=%b cnt=%0d full=%b, required 0/%0d/%b",
                             c, bus.register_ready, bus.count, bus.full, k, (k == DEPTH));
                else passed++;
            end
        end
        bus.in_valid     = 1'b0;
        bus.bank_release = 1'b1;
        cycle();
        bus.bank_release = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h40 + i);
            cycle();
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.register_ready, bus.full, bus.count, bus.wr_addr, bus.wr_data, bus.ovf_err} !== '0)
            $display("FAIL midreset_async: rdy=%b strb=%b full=%b cnt=%0d addr=%0d data=%h ovf=%b, required all 0",
                     bus.in_ready, bus.register_ready, bus.full, bus.count, bus.wr_addr, bus.wr_data, bus.ovf_err);
        else passed++;
        cycle();
        rst_n = 1'b1;
        cycle();
        bus.start = 1'b1;
        cycle();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        cycle();
        bus.in_valid = 1'b0;
        total++;
        if ({bus.register_ready, bus.wr_addr, bus.wr_data, bus.count} !== {1'b1, 4'd0, 8'h55, 5'd1})
            $display("FAIL midreset_restart: strb=%b addr=%0d data=%h cnt=%0d, required 1/0/55/1",
                     bus.register_ready, bus.wr_addr, bus.wr_data, bus.count);
        else passed++;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_ignored_controls();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.in_valid     = 1'b1;
            bus.in_data      = 8'(8'h80 + i);
            bus.start        = (i == 4);
            bus.bank_release = (i == 9);
            cycle();
            total++;
            if ({bus.register_ready, bus.wr_addr, bus.wr_data, bus.count} !== {1'b1, 4'(i), 8'(8'h80 + i), 5'(i + 1)})
                $display("FAIL ignore_elem%0d: strb=%b addr=%0d data=%h cnt=%0d, required 1/%0d/%h/%0d",
                         i, bus.register_ready, bus.wr_addr, bus.wr_data, bus.count, i, 8'(8'h80 + i), i + 1);
            else passed++;
        end
        bus.in_valid = 1'b0; bus.start = 1'b0; bus.bank_release = 1'b0;
        total++;
        if (bus.full !== 1'b1) $display("FAIL ignore_full: full=%b required 1", bus.full);
        else passed++;
        bus.bank_release = 1'b1;
        cycle();
        bus.bank_release = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            int bad;
            bad = 0;
            bus.start = 1'b1;
            cycle();
            bus.start = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'(8'hC0 + 16 * m + i);
                cycle();
                if ({bus.register_ready, bus.wr_addr, bus.wr_data} !== {1'b1, 4'(i), 8'(8'hC0 + 16 * m + i)}) bad++;
            end
            bus.in_valid = 1'b0;
            total++;
            if (bad != 0 || bus.count !== 5'd16 || bus.full !== 1'b1)
                $display("FAIL b2b_matrix%0d: bad_strobes=%0d cnt=%0d full=%b, required 0/16/1",
                         m, bad, bus.count, bus.full);
            else passed++;
            bus.bank_release = 1'b1;
            cycle();
            bus.bank_release = 1'b0;
            total++;
            if ({bus.full, bus.count} !== {1'b0, 5'd0})
                $display("FAIL b2b_release%0d: full=%b cnt=%0d, required 0/0", m, bus.full, bus.count);
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_burst();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_ignored_controls();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
